cpp_internal_int_to_double_interp_convert: RTL and testbench
============================================================

// Module: cpp_internal_int_to_double_interp_convert
// PURPOSE
//  Clocked integer-to-IEEE-754-double converter for the CppSim/Verilog co-sim boundary.
//  Converts a 32-bit integer bus into 64-bit double bits, which the real-valued side reads with $bitstoreal.
//  It is the inverse path of the double-to-int interp converter.
//  A conversion is triggered by any toggle of update_in. update_out echoes update_in once out holds the new result.
//  The datapath is synthesizable: an iterative one-bit-per-cycle normalizer, with no real-type arithmetic.
// PARAMETERS
//  SIGNED_IN  1  1: in is two's complement; 0: in is unsigned
// PORTS
//  clk         input   1   single clock, rising edge
//  rst_n       input   1   asynchronous, active-low reset
//  in          input   32  integer value to convert
//  update_in   input   1   event line; any level change requests a conversion
//  out         output  64  IEEE-754 double bit pattern of the last converted value
//  update_out  output  1   equals update_in level captured at the start of the conversion now shown on out
//  busy        output  1   high from the capture edge until the PACK edge completes
// BEHAVIOUR
//  Reset (rst_n low, asynchronous)
//   - Outputs: out=64'h0 (+0.0), update_out=0, busy=0.
//   - Internal: update_q=0, state=IDLE.
//   - Reset asserted mid-conversion aborts it immediately; no partial result is ever written to out.
//  Event detection
//   - In IDLE, on each clk edge, if update_in != update_q then capture in and set update_q<=update_in.
//   - Also on that edge: sign<=SIGNED_IN&in[31]; mag<=sign?-in:in (32-bit unsigned); exp<=11'd1054; state<=NORM.
//   - If update_in is 1 when reset releases, a conversion of in starts on the first edge.
//  FSM: IDLE -> NORM -> PACK -> IDLE
//   - NORM: if mag==0 or mag[31]==1, go to PACK. Otherwise mag<=mag<<1 and exp<=exp-1, staying in NORM.
//   - PACK (single edge), nonzero mag: out<={sign,exp,mag[30:0],21'b0}.
//   - PACK, mag==0: out<=64'h0 (never -0.0).
//   - PACK, both cases: update_out<=update_q; busy<=0; state<=IDLE.
//  Arithmetic
//   - Every 32-bit input is exactly representable, so no rounding is performed.
//   - -2^31 magnitude is 0x80000000, with no overflow.
//   - Final exp = 1054 - lz, where lz = leading zeros of mag.
//  Latency
//   - Counted in edges after the capture edge: out and update_out change on edge lz+2.
//   - Zero input: 2 edges. Worst case (|in|=1): 33 edges.
//   - out and update_out change on the same edge, so a reader sampling on an update_out change sees a settled out.
//  Events while busy
//   - update_in changes are not captured while busy; in and update_in may change freely.
//   - On return to IDLE, if update_in != update_q, a new conversion of the current in starts on the next edge.
//   - Any even number of toggles during busy nets to no new conversion. Events are coalesced, never queued.
//   - Back-to-back: the capture edge may directly follow the PACK edge, with no idle cycle required.
//  out holds its value between conversions and is never driven X after reset.
// TESTING
//  1. SIGNED_IN=1, in=5, toggle update_in 0->1 -> out=64'h4014000000000000 and update_out=1, 31 edges after capture.
//  2. in=-1 -> out=64'hBFF0000000000000 at 33 edges. in=32'h80000000 -> out=64'hC1E0000000000000 at 2 edges.
//  3. in=0 after a nonzero result -> out=64'h0 at 2 edges, with busy high for exactly those 2 edges.
//  4. SIGNED_IN=0, in=32'hFFFFFFFF -> out=64'h41EFFFFFFFE00000. in=1 -> 64'h3FF0000000000000.
//  5. Toggle update_in once mid-conversion -> first result is posted, then the second conversion uses the in present at the re-capture edge.
//     Toggle twice mid-conversion -> no second conversion occurs.
//  6. Pull rst_n low mid-NORM -> out=0, update_out=0, busy=0 immediately.
//     With update_in=1 at release -> a conversion starts on the first edge.

Source files
------------

// File: rtl/cpp_internal_int_to_double_interp_convert_if.sv
// Signal bundle between the integer driver and the int-to-double converter.
// Protocol: the driver flips update_in (either direction) to request a conversion of in;
// the converter flips update_out to the captured update_in level on the same edge out is updated.
interface cpp_internal_int_to_double_interp_convert_if;
  logic [31:0] in;
  logic        update_in;
  logic [63:0] out;
  logic        update_out;
  logic        busy;

  modport master (
    output in,
    output update_in,
    input  out,
    input  update_out,
    input  busy
  );

  modport slave (
    input  in,
    input  update_in,
    output out,
    output update_out,
    output busy
  );
endinterface

// File: rtl/cpp_internal_int_to_double_interp_convert.sv
// Integer to IEEE-754 double bit pattern, one normalizing shift per clock.
// Every 32-bit integer fits a double's mantissa exactly, so no rounding stage exists.
module cpp_internal_int_to_double_interp_convert #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  cpp_internal_int_to_double_interp_convert_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        update_q, update_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [10:0] exp_q, exp_d;
  logic [63:0] out_q, out_d;
  logic        update_out_q, update_out_d;
  logic        busy_q, busy_d;

  logic        in_neg;
  logic [31:0] in_mag;

  always_comb begin
    state_d      = state_q;
    update_d     = update_q;
    sign_d       = sign_q;
    mag_d        = mag_q;
    exp_d        = exp_q;
    out_d        = out_q;
    update_out_d = update_out_q;
    busy_d       = busy_q;

    // -2^31 negates to 0x80000000, which is still the correct unsigned magnitude.
    in_neg = SIGNED_IN && bus.in[31];
    in_mag = in_neg ? (32'd0 - bus.in) : bus.in;

    case (state_q)
      IDLE: begin
        if (bus.update_in != update_q) begin
          update_d = bus.update_in;
          sign_d   = in_neg;
          mag_d    = in_mag;
          exp_d    = 11'd1054;
          busy_d   = 1'b1;
          state_d  = NORM;
        end
      end
      NORM: begin
        if ((mag_q == 32'd0) || mag_q[31]) begin
          state_d = PACK;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 11'd1;
        end
      end
      PACK: begin
        // Zero is always posted as +0.0, regardless of the captured sign.
        if (mag_q == 32'd0) begin
          out_d = 64'h0;
        end else begin
          out_d = {sign_q, exp_q, mag_q[30:0], 21'b0};
        end
        update_out_d = update_q;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      update_q     <= 1'b0;
      sign_q       <= 1'b0;
      mag_q        <= 32'd0;
      exp_q        <= 11'd0;
      out_q        <= 64'h0;
      update_out_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      update_q     <= update_d;
      sign_q       <= sign_d;
      mag_q        <= mag_d;
      exp_q        <= exp_d;
      out_q        <= out_d;
      update_out_q <= update_out_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.update_out = update_out_q;
  assign bus.busy       = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cpp_internal_int_to_double_interp_convert.sv
// Directed bench for the int-to-double converter: a signed and an unsigned instance,
// expected results queued at stimulus time and checked by a negedge monitor.
module tb_cpp_internal_int_to_double_interp_convert;

  localparam int W = 73;  // {out[63:0], update_out, latency[7:0]}

  logic clk;
  logic rst_n;
  logic [1:0] dbg_s, dbg_u;

  cpp_internal_int_to_double_interp_convert_if bus_s ();
  cpp_internal_int_to_double_interp_convert_if bus_u ();

  cpp_internal_int_to_double_interp_convert #(.SIGNED_IN(1'b1)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_s),
    .dbg_state (dbg_s)
  );

  cpp_internal_int_to_double_interp_convert #(.SIGNED_IN(1'b0)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_u),
    .dbg_state (dbg_u)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_chk  = 0;
  int n_fail = 0;
  logic upd_lvl[2];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [63:0]  m_out[2];
  logic         m_uo[2];
  logic         m_busy[2];
  logic         prev_uo[2];
  logic         prev_busy[2];
  int           cap_cyc[2];
  logic [W-1:0] mon_e;
  bit           mon_empty;

  always_comb begin
    m_out[0]  = bus_s.out;
    m_out[1]  = bus_u.out;
    m_uo[0]   = bus_s.update_out;
    m_uo[1]   = bus_u.update_out;
    m_busy[0] = bus_s.busy;
    m_busy[1] = bus_u.busy;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        prev_uo[d]   = 1'b0;
        prev_busy[d] = 1'b0;
        cap_cyc[d]   = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_busy[d] && !prev_busy[d]) cap_cyc[d] = cyc;
        if (m_uo[d] != prev_uo[d]) begin
          mon_empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
          if (mon_empty) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d_unexpected_result: got out=%h update_out=%b, expected no result",
                     d, m_out[d], m_uo[d]);
          end else begin
            if (d == 0) mon_e = exp_q0.pop_front();
            else        mon_e = exp_q1.pop_front();
            check64($sformatf("dut%0d_out", d), m_out[d], mon_e[W-1 -: 64]);
            check64($sformatf("dut%0d_update_out", d), {63'd0, m_uo[d]}, {63'd0, mon_e[8]});
            check64($sformatf("dut%0d_latency", d), 64'(cyc - cap_cyc[d]), {56'd0, mon_e[7:0]});
            check64($sformatf("dut%0d_busy_at_result", d), {63'd0, m_busy[d]}, 64'd0);
          end
        end
        prev_uo[d]   = m_uo[d];
        prev_busy[d] = m_busy[d];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fire(input int d, input logic [31:0] val, input logic [63:0] e_out,
                      input int lat, input bit expect_result);
    @(posedge clk);
    #2;
    upd_lvl[d] = ~upd_lvl[d];
    if (d == 0) begin
      bus_s.in        = val;
      bus_s.update_in = upd_lvl[d];
      if (expect_result) exp_q0.push_back({e_out, upd_lvl[d], 8'(lat)});
    end else begin
      bus_u.in        = val;
      bus_u.update_in = upd_lvl[d];
      if (expect_result) exp_q1.push_back({e_out, upd_lvl[d], 8'(lat)});
    end
  endtask

  task automatic drain(input int budget);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      pending = (exp_q0.size() != 0) || (exp_q1.size() != 0) || bus_s.busy || bus_u.busy;
    end
    n_chk++;
    if (pending) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d results still pending after %0d cycles, expected 0",
               exp_q0.size() + exp_q1.size(), budget);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check64({tag, "_s_out"},        bus_s.out, 64'h0);
    check64({tag, "_s_update_out"}, {63'd0, bus_s.update_out}, 64'd0);
    check64({tag, "_s_busy"},       {63'd0, bus_s.busy}, 64'd0);
    check64({tag, "_s_state"},      {62'd0, dbg_s}, 64'd0);
    check64({tag, "_u_out"},        bus_u.out, 64'h0);
    check64({tag, "_u_update_out"}, {63'd0, bus_u.update_out}, 64'd0);
    check64({tag, "_u_busy"},       {63'd0, bus_u.busy}, 64'd0);
    check64({tag, "_u_state"},      {62'd0, dbg_u}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n           = 1'b0;
    upd_lvl[0]      = 1'b0;
    upd_lvl[1]      = 1'b0;
    bus_s.in        = 32'd0;
    bus_s.update_in = 1'b0;
    bus_u.in        = 32'd0;
    bus_u.update_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // signed instance
    fire(0, 32'd5,        64'h4014000000000000, 31, 1'b1); drain(100);
    fire(0, 32'hFFFFFFFF, 64'hBFF0000000000000, 33, 1'b1); drain(100);
    fire(0, 32'h80000000, 64'hC1E0000000000000,  2, 1'b1); drain(100);
    fire(0, 32'd0,        64'h0000000000000000,  2, 1'b1); drain(100);
    fire(0, 32'd1000,     64'h408F400000000000, 24, 1'b1); drain(100);
    fire(0, 32'hFFFFFC18, 64'hC08F400000000000, 24, 1'b1); drain(100);
    fire(0, 32'h7FFFFFFF, 64'h41DFFFFFFFC00000,  3, 1'b1); drain(100);
    fire(0, 32'hC0000000, 64'hC1D0000000000000,  3, 1'b1); drain(100);

    // unsigned instance
    fire(1, 32'hFFFFFFFF, 64'h41EFFFFFFFE00000,  2, 1'b1); drain(100);
    fire(1, 32'd1,        64'h3FF0000000000000, 33, 1'b1); drain(100);
    fire(1, 32'h80000000, 64'h41E0000000000000,  2, 1'b1); drain(100);
    fire(1, 32'd0,        64'h0000000000000000,  2, 1'b1); drain(100);

    // both instances converting at once
    fire(0, 32'd2,        64'h4000000000000000, 32, 1'b1);
    fire(1, 32'd1000,     64'h408F400000000000, 24, 1'b1);
    drain(100);

    // one toggle while busy: re-capture right after PACK with the in present then
    fire(0, 32'd5,        64'h4014000000000000, 31, 1'b1);
    repeat (10) @(posedge clk);
    fire(0, 32'd3,        64'h4008000000000000, 32, 1'b1);
    drain(200);

    // two toggles while busy coalesce to nothing
    fire(0, 32'd2,        64'h4000000000000000, 32, 1'b1);
    repeat (5) @(posedge clk);
    fire(0, 32'h00001234, 64'h0, 0, 1'b0);
    repeat (3) @(posedge clk);
    fire(0, 32'h00000777, 64'h0, 0, 1'b0);
    drain(200);
    repeat (40) @(posedge clk);
    #2;
    check64("coalesce_busy",  {63'd0, bus_s.busy}, 64'd0);
    check64("coalesce_state", {62'd0, dbg_s}, 64'd0);
    check64("coalesce_out",   bus_s.out, 64'h4000000000000000);

    // reset in the middle of NORM, then release with update_in high
    fire(0, 32'd5, 64'h0, 0, 1'b0);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    upd_lvl[0]      = 1'b1;
    bus_s.in        = 32'd1000;
    bus_s.update_in = 1'b1;
    upd_lvl[1]      = 1'b0;
    bus_u.update_in = 1'b0;
    exp_q0.push_back({64'h408F400000000000, 1'b1, 8'd24});
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drain(100);

    repeat (5) @(posedge clk);
    #2;
    check64("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
